// File: rtl/wfid_slot_tracker.sv
// wfid_slot_tracker
// Tracks which wavefront slots are occupied. Each cycle it decodes the set and
// clear requests into one-hot vectors and updates a registered occupancy mask.
// It also keeps a registered occupancy count and reports full, empty and the
// lowest free slot.
// Optional macro WFID_SLOT_TRACKER_ERR_EN enables the sticky protocol-error
// flag. Without the macro, err is tied low and no error logic is built.

module wfid_slot_tracker #(
  parameter int ID_WIDTH  = 3,
  parameter int NUM_SLOTS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ID_WIDTH-1:0]  set_id,
  input  logic                 clr_en,
  input  logic [ID_WIDTH-1:0]  clr_id,
  output logic [NUM_SLOTS-1:0] mask,
  output logic [ID_WIDTH:0]    count,
  output logic                 full,
  output logic                 empty,
  output logic                 free_valid,
  output logic [ID_WIDTH-1:0]  free_id,
  output logic                 err
);

  // The popcount tree is built over a power-of-two number of leaves.
  // Leaves at or above NUM_SLOTS are tied to zero.
  localparam int PAD = 1 << ID_WIDTH;

  logic [NUM_SLOTS-1:0] set_dec;
  logic [NUM_SLOTS-1:0] clr_dec;
  logic [NUM_SLOTS-1:0] mask_q;
  logic [NUM_SLOTS-1:0] mask_next;
  logic [ID_WIDTH:0]    count_q;
  logic [ID_WIDTH:0]    count_next;
  logic [NUM_SLOTS-1:0] free_vec;
  logic [NUM_SLOTS-1:0] lowest_free;

  // An out-of-range ID matches no slot, so it decodes to all zeros.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_dec
    assign set_dec[i] = set_en && (set_id == ID_WIDTH'(i));
    assign clr_dec[i] = clr_en && (clr_id == ID_WIDTH'(i));
  end

  // Set is ORed in after the clear is applied. If both target the same slot,
  // the set wins.
  assign mask_next = (mask_q & ~clr_dec) | set_dec;

  // Binary adder tree. Level 0 holds the leaf bits. Each level halves the
  // number of nodes until level ID_WIDTH holds the total.
  for (genvar l = 0; l <= ID_WIDTH; l++) begin : g_lvl
    localparam int N = PAD >> l;
    logic [ID_WIDTH:0] sum [N];
    for (genvar k = 0; k < N; k++) begin : g_node
      if (l == 0) begin : g_leaf
        if (k < NUM_SLOTS) begin : g_used
          assign sum[k] = {{ID_WIDTH{1'b0}}, mask_next[k]};
        end else begin : g_pad
          assign sum[k] = '0;
        end
      end else begin : g_add
        assign sum[k] = g_lvl[l-1].sum[2*k] + g_lvl[l-1].sum[2*k+1];
      end
    end
  end

  assign count_next = g_lvl[ID_WIDTH].sum[0];

  // Occupancy mask and count register. Reset drops any pending requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      mask_q  <= mask_next;
      count_q <= count_next;
    end
  end

  // Isolate the lowest free slot as x & -x. When the mask is full, the
  // result is zero.
  assign free_vec    = ~mask_q;
  assign lowest_free = free_vec & (~free_vec + NUM_SLOTS'(1));

  // Returns the slot positions whose index has bit b set. These constants
  // turn the one-hot lowest_free vector into a binary index.
  function automatic logic [NUM_SLOTS-1:0] id_bit_sel(input int b);
    logic [NUM_SLOTS-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      s[i] = (((i >> b) & 1) == 1);
    end
    return s;
  endfunction

  // One-hot to binary encoder. Each free_id bit is the OR of the slots whose
  // index has that bit set.
  for (genvar b = 0; b < ID_WIDTH; b++) begin : g_enc
    localparam logic [NUM_SLOTS-1:0] SEL = id_bit_sel(b);
    assign free_id[b] = |(lowest_free & SEL);
  end

  assign mask       = mask_q;
  assign count      = count_q;
  assign full       = (count_q == (ID_WIDTH+1)'(NUM_SLOTS));
  assign empty      = (count_q == '0);
  assign free_valid = ~full;

`ifdef WFID_SLOT_TRACKER_ERR_EN
  logic err_q;
  logic same_id_clr;
  logic set_err;
  logic clr_err;

  // A set is only legal on a free slot, unless the same slot is cleared in
  // that cycle. A clear is only legal on an occupied slot. In both cases an
  // ID beyond NUM_SLOTS decodes to zero and is an error.
  assign same_id_clr = clr_en && (clr_id == set_id);
  assign set_err     = set_en && ((set_dec == '0) ||
                                  ((|(set_dec & mask_q)) && !same_id_clr));
  assign clr_err     = clr_en && ((clr_dec == '0) || (|(clr_dec & ~mask_q)));

  // Sticky error flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (set_err || clr_err) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
